// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types for the MIPS memory-stage load/store unit.
//   - access size encodings (SZ_BYTE / SZ_HALF / SZ_WORD, 2'b11 treated as word)
//   - FSM state enum
//   - default data-memory depth
//   - helpers to classify an access (sub-word, misaligned)
package mem_access_pkg;

    localparam int MEM_WORDS_DEFAULT = 1024;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Byte and half stores need the old word first (read-modify-write).
    function automatic logic is_subword(input logic [1:0] size);
        return (size == SZ_BYTE) || (size == SZ_HALF);
    endfunction

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// byte_lane_align: combinational little-endian lane steering.
//   Load path : rdata, addr, size, sext -> ld_result (extracted, zero/sign extended)
//   Store path: old_word, wdata, addr, size -> st_word (addressed lane replaced)
// Ports:
//   rdata     in  32  word read from memory (load source)
//   addr      in  2   byte offset within the word
//   size      in  2   access size encoding
//   sext      in  1   sign-extend sub-word loads
//   old_word  in  32  word being modified by a sub-word store
//   wdata     in  32  right-aligned store data
//   ld_result out 32  load value
//   st_word   out 32  word to write back
// Halfwords use addr[1] only and words ignore addr entirely, so misaligned
// accesses that are not trapped fall through as their aligned equivalent.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] ld_result,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = rdata[{addr, 3'b000} +: 8];
        ld_half   = rdata[{addr[1], 4'b0000} +: 16];
        ld_result = rdata;
        case (size)
            SZ_BYTE: ld_result = {{24{sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_result = {{16{sext & ld_half[15]}}, ld_half};
            default: ld_result = rdata;
        endcase
    end

    always_comb begin
        st_word = wdata;
        case (size)
            SZ_BYTE: begin
                st_word = old_word;
                st_word[{addr, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                st_word = old_word;
                st_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: st_word = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between EX/MEM and a word-wide data
// memory (combinational read, synchronous write). One request at a time;
// sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst (async, active low)
//   req_valid/req_ready handshake; req_write, req_size, req_signed,
//   req_addr (byte address), req_wdata (right-aligned)
//   resp_valid (1-cycle pulse), resp_rdata (0 for stores), misalign
//   mem_we, mem_addr (word index), mem_wdata, mem_rdata
// Option: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (straight to RESP with misalign=1, no memory access). Undefined,
// misalign is tied 0 and such accesses act as the aligned access.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
    parameter int AW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          misalign,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int IW = $clog2(MEM_WORDS);

    state_t        state_q, state_d;
    logic [IW+1:0] addr_q;     // only the bits that reach the word index and lanes
    logic [1:0]    size_q;
    logic          sext_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          accept;
    logic          req_mis;
    logic          mis_now;
    logic [31:0]   old_word;
    logic [31:0]   ld_result;
    logic [31:0]   st_word;

    // Address bits above the memory depth alias away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[AW-1:IW+2];

    assign accept = (state_q == IDLE) && req_valid;

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic mis_q;
    assign req_mis = is_misaligned(req_size, req_addr[1:0]);
    assign mis_now = mis_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        mis_q <= 1'b0;
        else if (accept) mis_q <= req_mis;
    end
`else
    assign req_mis = 1'b0;
    assign mis_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_mis)                                state_d = RESP;
                    else if (!req_write || is_subword(req_size)) state_d = READ;
                    else                                         state_d = WRITE;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[IW+1:0];
                size_q  <= req_size;
                sext_q  <= req_signed;
                write_q <= req_write;
                wdata_q <= req_wdata;
            end
            if (state_q == READ) rdata_q <= mem_rdata;
        end
    end

    // During READ the live memory word feeds the merge, so mem_wdata already
    // carries the final value and does not change when READ hands to WRITE.
    assign old_word = (state_q == READ) ? mem_rdata : rdata_q;

    byte_lane_align u_align (
        .rdata     (rdata_q),
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .sext      (sext_q),
        .old_word  (old_word),
        .wdata     (wdata_q),
        .ld_result (ld_result),
        .st_word   (st_word)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign misalign   = (state_q == RESP) && mis_now;
    assign resp_rdata = ((state_q == RESP) && !write_q && !mis_now) ? ld_result : 32'h0;
    assign mem_we     = (state_q == WRITE);
    assign mem_addr   = 32'(addr_q[IW+1:2]);
    assign mem_wdata  = write_q ? st_word : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit with a
// behavioural 1K-word data memory and a scoreboard queue of expected responses.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, misalign, mem_we;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

    typedef struct packed {
        logic [31:0] rd;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    int          errs   = 0;
    int          checks = 0;

    logic [31:0] mem [0:1023];
    bit          mem_init = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .misalign   (misalign),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[32'h20] <= 32'h0000_0005;
            mem[32'h11] <= 32'h1111_1111;
            mem_init    <= 1'b1;
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One request; the accepting edge ends cycle 0, outputs are sampled on
    // the falling edge of each following cycle.
    task automatic req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat,
                       input int exp_we, input logic [31:0] exp_mwd);
        int   lat    = -1;
        int   we_cnt = 0;
        int   waits  = 0;
        exp_t e;
        logic [31:0] exp_idx;
        exp_idx = {22'h0, a[11:2]};
        @(negedge clk);
        while (!req_ready && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
        req_addr  = a;    req_wdata = wd;
        sb_q.push_back('{rd: exp_rd, mis: exp_mis});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk({tag, "/mem_addr"}, mem_addr, exp_idx);
            if (k == 1 && exp_lat == 3) chk({tag, "/wdata_in_read"}, mem_wdata, exp_mwd);
            if (mem_we) begin
                we_cnt++;
                chk({tag, "/we_addr"}, mem_addr, exp_idx);
                chk({tag, "/we_data"}, mem_wdata, exp_mwd);
            end
            if (resp_valid) begin
                lat = k;
                e   = sb_q.pop_front();
                chk({tag, "/rdata"}, resp_rdata, e.rd);
                chk({tag, "/misalign"}, 32'(misalign), 32'(e.mis));
                break;
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/we_count"}, 32'(we_cnt), 32'(exp_we));
        if (sb_q.size() != 0) sb_q.delete();
    endtask

    initial begin
        int resp_seen;
        rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #12;
        chk("rst/req_ready",  32'(req_ready),  32'd1);
        chk("rst/resp_valid", 32'(resp_valid), 32'd0);
        chk("rst/resp_rdata", resp_rdata,      32'd0);
        chk("rst/misalign",   32'(misalign),   32'd0);
        chk("rst/mem_we",     32'(mem_we),     32'd0);
        chk("rst/mem_addr",   mem_addr,        32'd0);
        chk("rst/mem_wdata",  mem_wdata,       32'd0);
        @(negedge clk);
        rst = 1'b1;

        //   tag          w     size     sg    addr          wdata         exp_rd        mis  lat we exp_mwd
        req("lw80",      1'b0, SZ_WORD, 1'b0, 32'h80,       32'h0,        32'h0000_0005, 1'b0, 2, 0, 32'h0);
        req("sw40",      1'b1, SZ_WORD, 1'b0, 32'h40,       32'hDEADBEEF, 32'h0,         1'b0, 2, 1, 32'hDEADBEEF);
        req("lw40",      1'b0, SZ_WORD, 1'b0, 32'h40,       32'h0,        32'hDEADBEEF,  1'b0, 2, 0, 32'h0);
        req("sb41",      1'b1, SZ_BYTE, 1'b0, 32'h41,       32'h123456AA, 32'h0,         1'b0, 3, 1, 32'hDEADAAEF);
        req("lb41",      1'b0, SZ_BYTE, 1'b1, 32'h41,       32'h0,        32'hFFFFFFAA,  1'b0, 2, 0, 32'h0);
        req("lbu41",     1'b0, SZ_BYTE, 1'b0, 32'h41,       32'h0,        32'h0000_00AA, 1'b0, 2, 0, 32'h0);
        req("sh42",      1'b1, SZ_HALF, 1'b0, 32'h42,       32'hFFFF1234, 32'h0,         1'b0, 3, 1, 32'h1234AAEF);
        req("lh42",      1'b0, SZ_HALF, 1'b1, 32'h42,       32'h0,        32'h0000_1234, 1'b0, 2, 0, 32'h0);
        req("lh40",      1'b0, SZ_HALF, 1'b1, 32'h40,       32'h0,        32'hFFFFAAEF,  1'b0, 2, 0, 32'h0);
        req("lhu40",     1'b0, SZ_HALF, 1'b0, 32'h40,       32'h0,        32'h0000_AAEF, 1'b0, 2, 0, 32'h0);
        req("lw_rsvd",   1'b0, 2'b11,   1'b1, 32'h40,       32'h0,        32'h1234AAEF,  1'b0, 2, 0, 32'h0);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        req("lw42_mis",  1'b0, SZ_WORD, 1'b0, 32'h42,       32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
        req("lhu43_mis", 1'b0, SZ_HALF, 1'b0, 32'h43,       32'h0,        32'h0,         1'b1, 1, 0, 32'h0);
`else
        req("lw42",      1'b0, SZ_WORD, 1'b0, 32'h42,       32'h0,        32'h1234AAEF,  1'b0, 2, 0, 32'h0);
        req("lhu43",     1'b0, SZ_HALF, 1'b0, 32'h43,       32'h0,        32'h0000_1234, 1'b0, 2, 0, 32'h0);
`endif
        req("lw_wrap",   1'b0, SZ_WORD, 1'b0, 32'h1080,     32'h0,        32'h0000_0005, 1'b0, 2, 0, 32'h0);
        req("sw_top",    1'b1, SZ_WORD, 1'b0, 32'hFFFFFFFC, 32'hCAFEF00D, 32'h0,         1'b0, 2, 1, 32'hCAFEF00D);
        req("lw_top",    1'b0, SZ_WORD, 1'b0, 32'h0FFC,     32'h0,        32'hCAFEF00D,  1'b0, 2, 0, 32'h0);

        // Store aborted by reset in the middle of its WRITE cycle.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr  = 32'h44; req_wdata = 32'h5555_5555;
        @(posedge clk);
        #1 req_valid = 1'b0;
        #2 chk("abort/we_before", 32'(mem_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort/we_after",   32'(mem_we),     32'd0);
        chk("abort/req_ready",  32'(req_ready),  32'd1);
        chk("abort/resp_valid", 32'(resp_valid), 32'd0);
        chk("abort/mem_addr",   mem_addr,        32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        resp_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) resp_seen++;
        end
        chk("abort/no_resp",  32'(resp_seen), 32'd0);
        chk("abort/mem_word", mem[32'h11],    32'h1111_1111);
        req("lw44",      1'b0, SZ_WORD, 1'b0, 32'h44,       32'h0,        32'h1111_1111, 1'b0, 2, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator for the MIPS memory stage. Accepts one load or store request at a time from the pipeline. Translates the byte address to the word-indexed data memory. Performs byte and halfword accesses on the word-wide memory: loads use extraction, and sub-word stores use read-modify-write. Sits between the EX/MEM pipeline register and the 1K-word data memory, which has a combinational read port and a synchronous write port.

## Interface
- MEM_WORDS, 1024: memory depth in words. The word index wraps modulo MEM_WORDS.
- AW, 32: byte-address width.

- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- req_signed  in  1  sign-extend sub-word loads.
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; 0 for stores.
- misalign  out  1  qualified by resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word index = req_addr[log2(MEM_WORDS)+1:2], zero-extended.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- **IDLE**
  - req_ready=1.
  - On req_valid, register addr, size, signed, write and wdata.
  - Next state: misaligned (macro enabled) → RESP; load or sub-word store → READ; word store → WRITE.
- **READ**
  - mem_we=0.
  - rdata_q <= mem_rdata.
  - Next state: load → RESP; store → WRITE.
- **WRITE**
  - mem_we=1.
  - Word store: mem_wdata = wdata.
  - Sub-word store: mem_wdata = rdata_q with the addressed lane replaced by the low bits of wdata.
  - Next state: RESP.
- **RESP**
  - resp_valid=1.
  - resp_rdata = extracted load value (0 for stores or misaligned).
  - Next state: IDLE.
- Lanes are little-endian.
  - Byte k = bits [8k+7:8k], k=addr[1:0].
  - Half h = bits [16h+15:16h], h=addr[1].
- Sub-word loads are zero- or sign-extended per req_signed. req_signed is ignored for word loads.
- req_ready=0 in every state except IDLE. Requests presented then are not accepted and must be held.
- mem_addr and mem_wdata are held stable from READ through WRITE.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - resp_valid=0, resp_rdata=0, misalign=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - rdata_q=0.
- Latency, counted from the accepting edge (cycle 0):
  - Load: resp_valid in cycle 2.
  - Word store: mem_we high in cycle 1; memory updates at the end of cycle 1; resp_valid in cycle 2.
  - Sub-word store: READ in cycle 1, WRITE in cycle 2, resp_valid in cycle 3.
  - Misaligned (macro enabled): resp_valid in cycle 1, no memory access.
- Throughput: one request per 3–4 cycles. A new request is accepted in the cycle after RESP.
- mem_we is high for exactly one cycle per store and never for loads.
- Reset asserted in any state: immediate return to IDLE, and mem_we drops asynchronously.
  - A WRITE interrupted before its clock edge does not modify memory.
  - No resp_valid is produced for an aborted request.
- Address wrap: byte addresses ≥ 4·MEM_WORDS alias modulo MEM_WORDS. No error is raised.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN
  - Defined: a half access with addr[0]=1 or a word access with addr[1:0]≠0 goes directly to RESP with misalign=1 and resp_rdata=0. Memory is untouched.
  - Undefined: misalign is tied 0. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. These accesses proceed normally as the aligned access.

## Structure
- Package mem_access_pkg:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD),
  - state enum,
  - default MEM_WORDS.
- Sub-module byte_lane_align: purely combinational.
  - Load extraction and extension: rdata, addr[1:0], size, signed → result.
  - Store merge: old word, wdata, addr[1:0], size → new word.
- The top level holds the FSM and the registers.

## Test plan
- Reset memory and unit; lw 0x80 → mem_addr=0x20, resp_valid in cycle 2, resp_rdata=0x00000005, mem_we never high.
- sw 0x40 with wdata 0xDEADBEEF → mem_we=1 for one cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF; a following lw 0x40 → 0xDEADBEEF.
- sb 0x41 with 0xAA → READ then WRITE of 0xDEADAAEF, resp in cycle 3; lb 0x41 → 0xFFFFFFAA; lbu 0x41 → 0x000000AA.
- sh 0x42 with 0x1234 → word becomes 0x1234AAEF; lh 0x42 → 0x00001234; lh 0x40 → 0xFFFFAAEF.
- lw 0x42:
  - Macro defined → resp in cycle 1, misalign=1, rdata=0, no memory access.
  - Macro undefined → returns the word at index 0x10, misalign=0.
- sw 0x44 with rst pulsed low during WRITE → mem_we falls at once, req_ready=1, no resp_valid, and memory word 0x11 is unchanged.
